compare_count_drain: RTL and testbench



---
 rtl/compare_count_drain.sv | 137 +++++++++++++
 tb/tb_compare_count_drain.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/compare_count_drain.sv
// Drain stage for the three-way compare/count unit: mirrors the iteration stream,
// waits out the counter latency after DONE, then sends a checked snapshot as two words.
module compare_count_drain #(
   parameter int unsigned LAT = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        VALID,
   input  logic        LOOP,
   input  logic        CLR,
   input  logic        DONE,
   input  logic [31:0] Q0,
   input  logic [31:0] Q1,
   input  logic [31:0] Q2,
   output logic [63:0] OUT_DATA,
   output logic        OUT_VALID,
   output logic        OUT_LAST,
   input  logic        OUT_READY,
   output logic        ERR,
   output logic        OVR,
   output logic        BUSY
);

   localparam int unsigned WCNT_W = 4;
   localparam int unsigned DW     = 32;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_SEND0,
      S_SEND1
   } state_t;

   state_t              state, state_d;
   logic [WCNT_W-1:0]   wcnt, wcnt_d;
   logic [DW-1:0]       iter, iter_d;
   logic [DW-1:0]       iter_s, iter_s_d;
   logic [DW-1:0]       q2_s, q2_s_d;
   logic [2*DW-1:0]     data_d;
   logic                valid_d, last_d, err_d, ovr_d;
   logic                beat;
   logic                step;

   assign beat = OUT_VALID & OUT_READY;
   assign step = VALID & LOOP;

   // State and registered outputs
   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= S_IDLE;
         wcnt      <= '0;
         iter      <= '0;
         iter_s    <= '0;
         q2_s      <= '0;
         OUT_DATA  <= '0;
         OUT_VALID <= 1'b0;
         OUT_LAST  <= 1'b0;
         ERR       <= 1'b0;
         OVR       <= 1'b0;
         BUSY      <= 1'b0;
      end else begin
         state     <= state_d;
         wcnt      <= wcnt_d;
         iter      <= iter_d;
         iter_s    <= iter_s_d;
         q2_s      <= q2_s_d;
         OUT_DATA  <= data_d;
         OUT_VALID <= valid_d;
         OUT_LAST  <= last_d;
         ERR       <= err_d;
         OVR       <= ovr_d;
         BUSY      <= (state_d != S_IDLE);
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d  = state;
      wcnt_d   = wcnt;
      iter_d   = iter;
      iter_s_d = iter_s;
      q2_s_d   = q2_s;
      data_d   = OUT_DATA;
      valid_d  = OUT_VALID;
      last_d   = OUT_LAST;
      err_d    = ERR;
      ovr_d    = OVR;

      if ((state != S_IDLE) && (step || DONE)) begin
         ovr_d = 1'b1;
      end

      case (state)
         S_IDLE: begin
            if (step) begin
               iter_d = CLR ? DW'(1) : iter + DW'(1);
            end
            if (DONE) begin
               state_d = S_WAIT;
               wcnt_d  = WCNT_W'(LAT);
            end
         end
         S_WAIT: begin
            // Counter reaching 0 on this edge is the snapshot edge
            if (wcnt <= WCNT_W'(1)) begin
               wcnt_d   = '0;
               q2_s_d   = Q2;
               iter_s_d = iter;
               data_d   = {Q1, Q0};
               valid_d  = 1'b1;
               last_d   = 1'b0;
               err_d    = ((Q0 + Q1 + Q2) != iter);
               state_d  = S_SEND0;
            end else begin
               wcnt_d = WCNT_W'(wcnt - WCNT_W'(1));
            end
         end
         S_SEND0: begin
            if (beat) begin
               data_d  = {iter_s, q2_s};
               last_d  = 1'b1;
               state_d = S_SEND1;
            end
         end
         S_SEND1: begin
            if (beat) begin
               data_d  = '0;
               valid_d = 1'b0;
               last_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_compare_count_drain.sv
// Bench for compare_count_drain: a behavioural counter stage drives Q0..Q2 with LAT
// cycles of delay; runs are checked against a table and an arithmetic run model.
module tb_compare_count_drain;

   localparam int unsigned LAT = 2;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        VALID = 1'b0;
   logic        LOOP = 1'b0;
   logic        CLR = 1'b0;
   logic        DONE = 1'b0;
   logic        OUT_READY = 1'b0;
   logic [31:0] Q0, Q1, Q2;
   logic [63:0] OUT_DATA;
   logic        OUT_VALID, OUT_LAST, ERR, OVR, BUSY;

   logic [1:0]  cat = 2'd0;
   logic        preload = 1'b0;
   logic [95:0] cnt = '0;
   logic [95:0] pipe [LAT];
   int          cyc_n = 0;
   int          checks = 0;
   int          errors = 0;

   logic [31:0] exp_cnt [3];
   logic [31:0] exp_iter;
   logic [63:0] exp_w0, exp_w1;
   logic        exp_err;

   typedef struct {
      int          n;
      bit          clr;
      logic [31:0] cats;
      int          gap;
      int          st0;
      int          st1;
      logic [63:0] w0;
      logic [63:0] w1;
      logic        err;
   } vec_t;

   vec_t vt [4];

   compare_count_drain #(.LAT(LAT)) dut (
      .CLK(CLK), .RST(RST), .VALID(VALID), .LOOP(LOOP), .CLR(CLR), .DONE(DONE),
      .Q0(Q0), .Q1(Q1), .Q2(Q2),
      .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_LAST(OUT_LAST),
      .OUT_READY(OUT_READY), .ERR(ERR), .OVR(OVR), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc_n <= cyc_n + 1;

   // Counter stage stand-in: counts {gt,eq,lt}, visible LAT cycles after the input cycle
   function automatic logic [95:0] cnt_next(input logic [95:0] c, input logic v, input logic l,
                                            input logic cl, input logic [1:0] ct, input logic pre);
      logic [95:0] r;
      r = c;
      if (pre) r = 96'd7;
      else if (v && l) begin
         if (cl) r = '0;
         case (ct)
            2'd0:    r[31:0]  = r[31:0]  + 32'd1;
            2'd1:    r[63:32] = r[63:32] + 32'd1;
            default: r[95:64] = r[95:64] + 32'd1;
         endcase
      end
      return r;
   endfunction

   always @(posedge CLK) begin
      cnt     <= cnt_next(cnt, VALID, LOOP, CLR, cat, preload);
      pipe[0] <= cnt_next(cnt, VALID, LOOP, CLR, cat, preload);
      for (int k = 1; k < LAT; k++) begin
         pipe[k] <= preload ? 96'd7 : pipe[k-1];
      end
   end

   assign Q0 = pipe[LAT-1][31:0];
   assign Q1 = pipe[LAT-1][63:32];
   assign Q2 = pipe[LAT-1][95:64];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
      VALID = 1'b0;
      LOOP  = 1'b0;
      CLR   = 1'b0;
      DONE  = 1'b0;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      @(posedge CLK);
      #1;
      RST = 1'b0;
      exp_iter = '0;
      @(negedge CLK);
      chk("reset_data", OUT_DATA, 64'd0);
      chk("reset_flags", 64'({OUT_VALID, OUT_LAST, ERR, OVR, BUSY}), 64'd0);
      @(posedge CLK);
      #1;
   endtask

   // One full run: iterations, optional DONE gap, then drain both words under stalls
   task automatic do_run(input int n, input bit clr_first, input logic [31:0] cats, input int gap,
                         input int st0, input int st1, input bit inj,
                         output logic [63:0] w0, output logic [63:0] w1, output logic e);
      int got, t, first, budget, s0, s1, c;
      bit stalled, done_inj;
      logic [64:0] held;
      got = 0; t = 0; first = -1; budget = 0; s0 = st0; s1 = st1;
      stalled = 1'b0; done_inj = inj; held = '0; w0 = '0; w1 = '0; e = 1'b0;
      for (int i = 0; i < n; i++) begin
         c     = int'(cats[2*i +: 2]);
         VALID = 1'b1;
         LOOP  = 1'b1;
         CLR   = (i == 0) && clr_first;
         cat   = 2'(c);
         DONE  = (gap == 0) && (i == n - 1);
         if (CLR) begin
            exp_cnt[0] = '0; exp_cnt[1] = '0; exp_cnt[2] = '0;
            exp_iter = 32'd1;
         end else begin
            exp_iter = exp_iter + 32'd1;
         end
         exp_cnt[c] = exp_cnt[c] + 32'd1;
         if (DONE) t = cyc_n;
         tick();
      end
      for (int g = 1; g <= gap; g++) begin
         DONE = (g == gap);
         if (DONE) t = cyc_n;
         tick();
      end
      exp_w0  = {exp_cnt[1], exp_cnt[0]};
      exp_w1  = {exp_iter, exp_cnt[2]};
      exp_err = ((exp_cnt[0] + exp_cnt[1] + exp_cnt[2]) != exp_iter);
      while (got < 2 && budget < 200) begin
         if (inj && budget == 0) begin
            VALID = 1'b1; LOOP = 1'b1; cat = 2'd0;
         end
         if (done_inj && OUT_VALID && !OUT_LAST) begin
            DONE = 1'b1; done_inj = 1'b0;
         end
         if (OUT_VALID && !OUT_LAST && s0 > 0) begin
            OUT_READY = 1'b0; s0--;
         end else if (OUT_VALID && OUT_LAST && s1 > 0) begin
            OUT_READY = 1'b0; s1--;
         end else begin
            OUT_READY = 1'b1;
         end
         @(negedge CLK);
         if (budget == 0) chk("busy_after_done", 64'(BUSY), 64'd1);
         if (first < 0 && OUT_VALID) first = cyc_n;
         if (stalled) begin
            chk("hold_data", OUT_DATA, held[63:0]);
            chk("hold_flags", 64'({OUT_VALID, OUT_LAST}), 64'({1'b1, held[64]}));
         end
         stalled = OUT_VALID && !OUT_READY;
         held    = {OUT_LAST, OUT_DATA};
         if (OUT_VALID && OUT_READY) begin
            chk("last_flag", 64'(OUT_LAST), (got == 1) ? 64'd1 : 64'd0);
            if (got == 0) begin
               w0 = OUT_DATA;
               e  = ERR;
            end else begin
               w1 = OUT_DATA;
            end
            got++;
         end
         tick();
         budget++;
      end
      OUT_READY = 1'b0;
      chk("words_seen", 64'(got), 64'd2);
      chk("first_valid_cycle", 64'(first), 64'(t + int'(LAT) + 1));
      @(negedge CLK);
      chk("idle_after_run", 64'({BUSY, OUT_VALID}), 64'd0);
      @(posedge CLK);
      #1;
   endtask

   // Start a run and reset it either in WAIT or in a stalled SEND1
   task automatic abort_run(input bit in_send1);
      for (int i = 0; i < 3; i++) begin
         VALID = 1'b1; LOOP = 1'b1; CLR = (i == 0); cat = 2'd0; DONE = (i == 2);
         tick();
      end
      if (in_send1) begin
         OUT_READY = 1'b1;
         for (int k = 0; k < 20 && !(OUT_VALID && OUT_LAST); k++) tick();
         OUT_READY = 1'b0;
         chk("reached_send1", 64'({OUT_VALID, OUT_LAST}), 64'd3);
      end
      do_reset();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] w0, w1;
      logic        e;
      logic [31:0] cats;
      int          n;
      exp_cnt[0] = '0; exp_cnt[1] = '0; exp_cnt[2] = '0;
      exp_iter   = '0;

      vt[0] = '{5, 1'b1, 32'h290, 0, 0, 0, 64'h00000001_00000002, 64'h00000005_00000002, 1'b0};
      vt[1] = '{5, 1'b1, 32'h290, 0, 3, 2, 64'h00000001_00000002, 64'h00000005_00000002, 1'b0};
      vt[2] = '{1, 1'b1, 32'h001, 3, 0, 0, 64'h00000001_00000000, 64'h00000001_00000000, 1'b0};
      vt[3] = '{3, 1'b1, 32'h02A, 1, 1, 1, 64'h00000000_00000000, 64'h00000003_00000003, 1'b0};

      do_reset();

      for (int i = 0; i < 4; i++) begin
         do_run(vt[i].n, vt[i].clr, vt[i].cats, vt[i].gap, vt[i].st0, vt[i].st1, 1'b0, w0, w1, e);
         chk($sformatf("tbl%0d_w0", i), w0, vt[i].w0);
         chk($sformatf("tbl%0d_w1", i), w1, vt[i].w1);
         chk($sformatf("tbl%0d_err", i), 64'(e), 64'(vt[i].err));
      end
      chk("ovr_clean", 64'(OVR), 64'd0);

      // Preloaded counter without CLR must fail the sum check, then a CLR run recovers
      do_reset();
      preload = 1'b1;
      tick();
      preload = 1'b0;
      exp_cnt[0] = 32'd7; exp_cnt[1] = '0; exp_cnt[2] = '0;
      do_run(2, 1'b0, 32'h9, 0, 0, 0, 1'b0, w0, w1, e);
      chk("pre_w0", w0, 64'h00000001_00000007);
      chk("pre_w1", w1, 64'h00000002_00000001);
      chk("pre_err", 64'(e), 64'd1);
      do_run(2, 1'b1, 32'h9, 0, 0, 0, 1'b0, w0, w1, e);
      chk("clr_w0", w0, 64'h00000001_00000000);
      chk("clr_w1", w1, 64'h00000002_00000001);
      chk("clr_err", 64'(e), 64'd0);

      for (int r = 0; r < 8; r++) begin
         n = int'($urandom_range(1, 6));
         cats = '0;
         for (int i = 0; i < n; i++) cats[2*i +: 2] = 2'($urandom_range(0, 2));
         do_run(n, 1'($urandom_range(0, 1)), cats, int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0, w0, w1, e);
         chk("rnd_w0", w0, exp_w0);
         chk("rnd_w1", w1, exp_w1);
         chk("rnd_err", 64'(e), 64'(exp_err));
      end

      // Protocol violations are ignored but flagged stickily
      do_run(3, 1'b1, 32'h24, 0, 2, 0, 1'b1, w0, w1, e);
      chk("ovr_w0", w0, 64'h00000001_00000001);
      chk("ovr_w1", w1, 64'h00000003_00000001);
      chk("ovr_set", 64'(OVR), 64'd1);
      do_run(1, 1'b1, 32'h0, 0, 0, 0, 1'b0, w0, w1, e);
      chk("ovr_next_w0", w0, exp_w0);
      chk("ovr_sticky", 64'(OVR), 64'd1);
      do_reset();

      abort_run(1'b0);
      do_run(vt[0].n, 1'b1, vt[0].cats, 0, 0, 0, 1'b0, w0, w1, e);
      chk("after_wait_rst_w0", w0, vt[0].w0);
      chk("after_wait_rst_w1", w1, vt[0].w1);

      abort_run(1'b1);
      do_run(vt[0].n, 1'b1, vt[0].cats, 0, 1, 1, 1'b0, w0, w1, e);
      chk("after_send1_rst_w0", w0, vt[0].w0);
      chk("after_send1_rst_w1", w1, vt[0].w1);
      chk("after_send1_rst_err", 64'(e), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
